// File: rtl/writeback_queue.sv
// writeback_queue: circular FIFO that merges ALU and load results onto the single register file write port.
// Optional bypass lookup is compiled in by defining WRITEBACK_QUEUE_BYPASS_EN.
// Ports: clk, rstn (async active-low); alu_*/mem_* enqueue channels, where mem has priority;
// rd/rd_data/write_en drive the regfile; wb_stall blocks the write port; reserve_en/reserve_rd
// set busy bits; busy is the pending bitmap; count is occupancy; rs1/rs2 -> fwd*_valid/fwd*_data.
module writeback_queue #(
  parameter int xlen  = 64,
  parameter int depth = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [4:0]                   alu_rd,
  input  logic [xlen-1:0]              alu_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [4:0]                   mem_rd,
  input  logic [xlen-1:0]              mem_data,
  output logic [4:0]                   rd,
  output logic [xlen-1:0]              rd_data,
  output logic                         write_en,
  input  logic                         wb_stall,
  input  logic                         reserve_en,
  input  logic [4:0]                   reserve_rd,
  output logic [31:0]                  busy,
  output logic [$clog2(depth+1)-1:0]   count,
  input  logic [4:0]                   rs1,
  input  logic [4:0]                   rs2,
  output logic                         fwd1_valid,
  output logic                         fwd2_valid,
  output logic [xlen-1:0]              fwd1_data,
  output logic [xlen-1:0]              fwd2_data
);

  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth+1);

  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic [31:0]     busy_q, busy_d;
  logic [4:0]      rd_mem_q [depth];
  logic [4:0]      rd_mem_d [depth];
  logic [xlen-1:0] data_mem_q [depth];
  logic [xlen-1:0] data_mem_d [depth];

  logic            enq_mem;
  logic            enq_alu;
  logic            enq;
  logic            pop;
  logic            not_empty;
  logic [4:0]      in_rd;
  logic [xlen-1:0] in_data;

  // Ready looks only at the registered full flag, so a pop this
  // cycle never opens a slot for a same-cycle enqueue.
  always_comb begin
    mem_ready = rstn && !full_q;
    alu_ready = rstn && !full_q && !mem_valid;
    enq_mem   = mem_valid && mem_ready;
    enq_alu   = alu_valid && alu_ready;
    enq       = enq_mem || enq_alu;
    in_rd     = enq_mem ? mem_rd : alu_rd;
    in_data   = enq_mem ? mem_data : alu_data;
  end

  always_comb begin
    not_empty = (count_q != '0);
    rd        = not_empty ? rd_mem_q[head_q] : '0;
    rd_data   = not_empty ? data_mem_q[head_q] : '0;
    pop       = not_empty && !wb_stall;
    write_en  = pop && (rd != 5'd0);
  end

  always_comb begin
    head_d     = pop ? head_q + 1'b1 : head_q;
    tail_d     = enq ? tail_q + 1'b1 : tail_q;
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    if (enq) begin
      rd_mem_d[tail_q]   = in_rd;
      data_mem_d[tail_q] = in_data;
    end
    case ({enq, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d = (count_d == CW'(depth));
  end

  // Set is applied after clear so a same-cycle reserve wins.
  always_comb begin
    busy_d = busy_q;
    if (write_en) begin
      busy_d[rd] = 1'b0;
    end
    if (reserve_en && reserve_rd != 5'd0) begin
      busy_d[reserve_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      busy_q  <= '0;
      for (int i = 0; i < depth; i++) begin
        rd_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      full_q     <= full_d;
      busy_q     <= busy_d;
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

  assign busy  = busy_q;
  assign count = count_q;

`ifdef WRITEBACK_QUEUE_BYPASS_EN
  // Walk oldest to youngest; the last hit is the youngest match.
  function automatic logic [xlen:0] lookup(input logic [4:0] rs);
    logic [xlen:0] r;
    logic [PW-1:0] idx;
    r = '0;
    for (int i = 0; i < depth; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q && rs != 5'd0 && rd_mem_q[idx] == rs) begin
        r = {1'b1, data_mem_q[idx]};
      end
    end
    return r;
  endfunction

  always_comb begin
    {fwd1_valid, fwd1_data} = lookup(rs1);
    {fwd2_valid, fwd2_data} = lookup(rs2);
  end
`else
  logic unused_rs;
  assign unused_rs  = ^{rs1, rs2};
  assign fwd1_valid = 1'b0;
  assign fwd2_valid = 1'b0;
  assign fwd1_data  = '0;
  assign fwd2_data  = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed and random checks of writeback_queue
// against a queue-based reference model.
module tb_writeback_queue;

  localparam int XL = 64;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          alu_valid, alu_ready;
  logic [4:0]    alu_rd;
  logic [XL-1:0] alu_data;
  logic          mem_valid, mem_ready;
  logic [4:0]    mem_rd;
  logic [XL-1:0] mem_data;
  logic [4:0]    rd;
  logic [XL-1:0] rd_data;
  logic          write_en;
  logic          wb_stall;
  logic          reserve_en;
  logic [4:0]    reserve_rd;
  logic [31:0]   busy;
  logic [2:0]    count;
  logic [4:0]    rs1, rs2;
  logic          fwd1_valid, fwd2_valid;
  logic [XL-1:0] fwd1_data, fwd2_data;

  writeback_queue #(.xlen(XL), .depth(DP)) dut (
    .clk(clk), .rstn(rstn),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_data(mem_data),
    .rd(rd), .rd_data(rd_data), .write_en(write_en),
    .wb_stall(wb_stall),
    .reserve_en(reserve_en), .reserve_rd(reserve_rd),
    .busy(busy), .count(count),
    .rs1(rs1), .rs2(rs2),
    .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    r;
    logic [XL-1:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_busy;
  int          checks = 0;
  int          errors = 0;

`ifdef WRITEBACK_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [XL:0] exp_fwd(logic [4:0] rs);
    logic [XL:0] r;
    r = '0;
    foreach (q[i]) begin
      if (rs != 5'd0 && q[i].r == rs) r = {1'b1, q[i].d};
    end
    if (!BYP) r = '0;
    return r;
  endfunction

  task automatic model_clear();
    q.delete();
    m_busy = '0;
  endtask

  task automatic set_idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    wb_stall = 0; reserve_en = 0; reserve_rd = 0;
    rs1 = 0; rs2 = 0;
  endtask

  // Compare every output with the model, then advance the model
  // to what the coming rising edge should produce.
  task automatic step();
    bit          full, pop, we;
    logic [XL:0] f1, f2;
    #1;
    full = (q.size() == DP);
    f1 = exp_fwd(rs1);
    f2 = exp_fwd(rs2);
    chk("mem_ready", mem_ready, !full);
    chk("alu_ready", alu_ready, !full && !mem_valid);
    chk("count", count, q.size());
    chk("rd", rd, q.size() > 0 ? q[0].r : 5'd0);
    chk("rd_data", rd_data, q.size() > 0 ? q[0].d : '0);
    pop = (q.size() > 0) && !wb_stall;
    we  = pop && q[0].r != 5'd0;
    chk("write_en", write_en, we);
    chk("busy", busy, m_busy);
    chk("fwd1_valid", fwd1_valid, f1[XL]);
    chk("fwd1_data", fwd1_data, f1[XL-1:0]);
    chk("fwd2_valid", fwd2_valid, f2[XL]);
    chk("fwd2_data", fwd2_data, f2[XL-1:0]);
    if (pop) begin
      if (we) m_busy[q[0].r] = 1'b0;
      void'(q.pop_front());
    end
    if (reserve_en) m_busy[reserve_rd] = 1'b1;
    m_busy[0] = 1'b0;
    if (!full && mem_valid) q.push_back('{mem_rd, mem_data});
    else if (!full && alu_valid) q.push_back('{alu_rd, alu_data});
    @(negedge clk);
  endtask

  task automatic push_alu(logic [4:0] r, logic [XL-1:0] d);
    alu_valid = 1; alu_rd = r; alu_data = d;
    step();
    alu_valid = 0;
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_we"}, write_en, 0);
    chk({tag, "_rd"}, rd, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_alu_ready"}, alu_ready, 0);
    chk({tag, "_mem_ready"}, mem_ready, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rstn = 0;
    set_idle();
    alu_valid = 1;
    model_clear();
    #2 reset_checks("rst");
    alu_valid = 0;
    @(negedge clk);
    rstn = 1;

    // first cycle out of reset: both channels ready
    #1 chk("post_rst_alu_ready", alu_ready, 1);
    chk("post_rst_mem_ready", mem_ready, 1);
    step();

    // single write
    push_alu(5'd5, 64'h1234);
    #1 chk("single_we", write_en, 1);
    chk("single_rd", rd, 5);
    chk("single_data", rd_data, 64'h1234);
    step();
    #1 chk("single_count0", count, 0);

    // arbitration: mem first, alu held off
    alu_valid = 1; alu_rd = 3; alu_data = 64'h33;
    mem_valid = 1; mem_rd = 4; mem_data = 64'h44;
    #1 chk("arb_alu_ready", alu_ready, 0);
    chk("arb_mem_ready", mem_ready, 1);
    step();
    mem_valid = 0;
    #1 chk("arb_first_rd", rd, 4);
    chk("arb_first_we", write_en, 1);
    step();
    alu_valid = 0;
    #1 chk("arb_second_rd", rd, 3);
    chk("arb_second_we", write_en, 1);
    step();

    // fill under stall, then drain in order
    wb_stall = 1;
    for (int i = 0; i < 4; i++) push_alu(5'(10 + i), 64'(100 + i));
    #1 chk("full_count", count, 4);
    chk("full_alu_ready", alu_ready, 0);
    chk("full_mem_ready", mem_ready, 0);
    step();
    wb_stall = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("drain_rd", rd, 5'(10 + i));
      chk("drain_we", write_en, 1);
      step();
    end
    #1 chk("drain_ready", alu_ready, 1);
    chk("drain_count", count, 0);

    // scoreboard
    reserve_en = 1; reserve_rd = 7;
    step();
    reserve_en = 0;
    #1 chk("busy7_set", busy[7], 1);
    push_alu(5'd7, 64'h77);
    #1 chk("busy7_we", write_en, 1);
    step();
    #1 chk("busy7_clear", busy[7], 0);
    push_alu(5'd7, 64'h78);
    reserve_en = 1; reserve_rd = 7;
    #1 chk("busy7_race_we", write_en, 1);
    step();
    reserve_en = 0;
    #1 chk("busy7_set_wins", busy[7], 1);
    push_alu(5'd7, 64'h79);
    step();
    reserve_en = 1; reserve_rd = 0;
    step();
    reserve_en = 0;
    #1 chk("busy_rd0", busy, 0);

    // rd=0 entry popped without a write
    push_alu(5'd0, 64'h55);
    #1 chk("rd0_we", write_en, 0);
    chk("rd0_count", count, 1);
    step();
    #1 chk("rd0_popped", count, 0);

    // bypass: youngest of two rd=9 entries
    wb_stall = 1;
    push_alu(5'd9, 64'hA);
    push_alu(5'd9, 64'hB);
    rs1 = 9;
    #1 chk("byp_valid", fwd1_valid, BYP);
    chk("byp_data", fwd1_data, BYP ? 64'hB : 64'h0);
    step();
    rs1 = 0;

    // reset with three queued entries
    push_alu(5'd20, 64'h20);
    #1 chk("pre_rst_count", count, 3);
    #2;
    wb_stall = 0;
    rstn = 0;
    #1 reset_checks("mid_rst");
    model_clear();
    @(negedge clk);
    rstn = 1;
    for (int i = 0; i < 3; i++) step();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      alu_valid  = ($urandom_range(0, 99) < 60);
      alu_rd     = 5'($urandom_range(0, 15));
      alu_data   = {$urandom, $urandom};
      mem_valid  = ($urandom_range(0, 99) < 35);
      mem_rd     = 5'($urandom_range(0, 15));
      mem_data   = {$urandom, $urandom};
      wb_stall   = ($urandom_range(0, 99) < 40);
      reserve_en = ($urandom_range(0, 99) < 30);
      reserve_rd = 5'($urandom_range(0, 15));
      rs1        = 5'($urandom_range(0, 15));
      rs2        = 5'($urandom_range(0, 15));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
